// File: rtl/fir_uart_pkg.sv
// Constants and types shared by the UART-to-FIR sample path.
package fir_uart_pkg;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int BYTE_W   = 8;
  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    COLLECT
  } asm_state_t;

  // Index width that stays legal when only one value is needed.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sample_assembler_if.sv
// Sample stream from the assembler FIFO to the FIR core (valid/ready).
interface uart_sample_assembler_if
  import fir_uart_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);

  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output sample_out,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_out,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO; the head is held in a register so it
// keeps its last value once the FIFO drains.
module sample_fifo
  import fir_uart_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_plus1;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] dout_reg;
  logic             push_ok, pop_ok;

  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_C);
  assign pop_ok       = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok      = push && (!full || pop_ok);
  assign rd_ptr_plus1 = rd_ptr_reg + 1'b1;

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_plus1;
      end
      count_reg <= count_next;
      // New word becomes head directly when nothing older will remain.
      if (push_ok && (empty || ((count_reg == ONE_C) && pop_ok))) begin
        dout_reg <= din;
      end else if (pop_ok && (count_reg > ONE_C)) begin
        dout_reg <= mem[rd_ptr_plus1];
      end
    end
  end

  assign dout  = dout_reg;
  assign count = count_reg;

endmodule

// File: rtl/uart_sample_assembler.sv
// Packs UART bytes LSB-first into FIR samples and queues them in a FWFT FIFO.
// Optional inter-byte timeout resync is enabled with `SAMPLE_TIMEOUT_EN.
module uart_sample_assembler
  import fir_uart_pkg::*;
#(
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int FIFO_DEPTH       = 4
`ifdef SAMPLE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES   = 13020
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_ready,
  input  logic [BYTE_W-1:0]           rx_data,
  uart_sample_assembler_if.master     fir,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int WORD_W = BYTE_W * BYTES_PER_SAMPLE;
  localparam int IDX_W  = bits_for(BYTES_PER_SAMPLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_SAMPLE - 1);

  asm_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [WORD_W-1:0] partial_reg, partial_next, lane_wr;
  logic [WORD_W-1:0] fifo_dout;
  logic              push, pop, full, empty;
  logic              overflow_reg;

`ifdef SAMPLE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_reg, tmo_next;
`endif

  // Partial word with the incoming byte dropped into lane idx; on the last
  // lane this is the complete sample handed to the FIFO.
  generate
    for (genvar gi = 0; gi < BYTES_PER_SAMPLE; gi++) begin : g_lane
      assign lane_wr[gi*BYTE_W +: BYTE_W] = (idx_reg == IDX_W'(gi)) ?
                                            rx_data : partial_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    partial_next = partial_reg;
    push         = 1'b0;
`ifdef SAMPLE_TIMEOUT_EN
    tmo_next     = '0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (rx_ready) begin
          partial_next = lane_wr;
          if (idx_reg == LAST_IDX) begin
            push = 1'b1;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (rx_ready) begin
          partial_next = lane_wr;
          if (idx_reg == LAST_IDX) begin
            push       = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
`ifdef SAMPLE_TIMEOUT_EN
        else if (tmo_reg == TMO_LIMIT) begin
          partial_next = '0;
          idx_next     = '0;
          state_next   = IDLE;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign pop = !empty && fir.sample_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      partial_reg  <= '0;
      overflow_reg <= 1'b0;
`ifdef SAMPLE_TIMEOUT_EN
      tmo_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      partial_reg  <= partial_next;
      overflow_reg <= push && full && !pop;
`ifdef SAMPLE_TIMEOUT_EN
      tmo_reg      <= tmo_next;
`endif
    end
  end

  sample_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (lane_wr),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign fir.sample_out   = fifo_dout;
  assign fir.sample_valid = !empty;
  assign overflow         = overflow_reg;

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Directed bench for uart_sample_assembler driven with 1-cycle rx strobes.
module tb_uart_sample_assembler;
  import fir_uart_pkg::*;

  localparam int TIMEOUT_CYCLES = 13020;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic [2:0] fifo_count;
  logic       overflow;
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;

  uart_sample_assembler_if fir ();

  uart_sample_assembler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .fir        (fir),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (cyc > 60000) begin
      $display("FAIL watchdog: got %0d cycles, want under 60000", cyc);
      $fatal(1);
    end
  end

  // Called at a negedge; returns at the next negedge with the strobe consumed.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fir.sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (fir.sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", fir.sample_valid); end
    vectors++; if (fir.sample_out !== 16'h0000) begin miscompares++; $display("FAIL reset_out: got %h want 0000", fir.sample_out); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_single_sample();
    fir.sample_ready = 1'b1;
    send_byte(8'h34);
    vectors++; if (fir.sample_valid !== 1'b0) begin miscompares++; $display("FAIL t1_half_valid: got %b want 0", fir.sample_valid); end
    send_byte(8'h12);
    vectors++; if (fir.sample_valid !== 1'b1) begin miscompares++; $display("FAIL t1_valid: got %b want 1", fir.sample_valid); end
    vectors++; if (fir.sample_out !== 16'h1234) begin miscompares++; $display("FAIL t1_out: got %h want 1234", fir.sample_out); end
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL t1_count: got %0d want 1", fifo_count); end
    @(negedge clk);
    vectors++; if (fir.sample_valid !== 1'b0) begin miscompares++; $display("FAIL t1_valid_drop: got %b want 0", fir.sample_valid); end
    vectors++; if (fir.sample_out !== 16'h1234) begin miscompares++; $display("FAIL t1_out_hold: got %h want 1234", fir.sample_out); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL t1_count_after: got %0d want 0", fifo_count); end
    $display("single sample 0x1234 checked");
  endtask

  task automatic test_overflow();
    fir.sample_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send_sample(16'(k));
    end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL t2_count_full: got %0d want 4", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t2_no_ovf: got %b want 0", overflow); end
    vectors++; if (fir.sample_out !== 16'h0001) begin miscompares++; $display("FAIL t2_head: got %h want 0001", fir.sample_out); end
    send_sample(16'h0005);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t2_ovf: got %b want 1", overflow); end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL t2_count_ovf: got %0d want 4", fifo_count); end
    @(negedge clk);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t2_ovf_pulse: got %b want 0", overflow); end
    fir.sample_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vectors++; if (fir.sample_valid !== 1'b1) begin miscompares++; $display("FAIL t2_pop_valid: got %b want 1", fir.sample_valid); end
      vectors++; if (fir.sample_out !== 16'(k)) begin miscompares++; $display("FAIL t2_pop_data: got %h want %h", fir.sample_out, 16'(k)); end
      @(negedge clk);
    end
    vectors++; if (fir.sample_valid !== 1'b0) begin miscompares++; $display("FAIL t2_drained: got %b want 0", fir.sample_valid); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL t2_count_end: got %0d want 0", fifo_count); end
    fir.sample_ready = 1'b0;
    $display("overflow scenario checked");
  endtask

  task automatic test_full_push_pop();
    sample_t exp_q [4];
    exp_q = '{16'h00A2, 16'h00A3, 16'h00A4, 16'h00B5};
    fir.sample_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send_sample(16'h00A0 + 16'(k));
    end
    send_byte(8'hB5);
    rx_data = 8'h00;
    rx_ready = 1'b1;
    fir.sample_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    fir.sample_ready = 1'b0;
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL t3_count: got %0d want 4", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t3_ovf: got %b want 0", overflow); end
    fir.sample_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (fir.sample_out !== exp_q[k]) begin miscompares++; $display("FAIL t3_order: got %h want %h", fir.sample_out, exp_q[k]); end
      @(negedge clk);
    end
    vectors++; if (fir.sample_valid !== 1'b0) begin miscompares++; $display("FAIL t3_drained: got %b want 0", fir.sample_valid); end
    fir.sample_ready = 1'b0;
    $display("full push+pop checked");
  endtask

  task automatic test_signed_and_reset();
    fir.sample_ready = 1'b0;
    send_sample(16'h80FF);
    vectors++; if (fir.sample_out !== 16'h80FF) begin miscompares++; $display("FAIL t4_out: got %h want 80ff", fir.sample_out); end
    vectors++; if (int'($signed(fir.sample_out)) != -32513) begin miscompares++; $display("FAIL t4_signed: got %0d want -32513", $signed(fir.sample_out)); end
    fir.sample_ready = 1'b1;
    @(negedge clk);
    fir.sample_ready = 1'b0;
    send_byte(8'hFF);
    rst_n = 1'b0;
    #1;
    vectors++; if (fir.sample_out !== 16'h0000) begin miscompares++; $display("FAIL t4_rst_out: got %h want 0000", fir.sample_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (fir.sample_valid !== 1'b0) begin miscompares++; $display("FAIL t4_rst_valid: got %b want 0", fir.sample_valid); end
    send_sample(16'h5678);
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL t4_resync_count: got %0d want 1", fifo_count); end
    vectors++; if (fir.sample_out !== 16'h5678) begin miscompares++; $display("FAIL t4_resync_out: got %h want 5678", fir.sample_out); end
    fir.sample_ready = 1'b1;
    @(negedge clk);
    fir.sample_ready = 1'b0;
    $display("signed sample and mid-sample reset checked");
  endtask

  task automatic test_timeout();
    fir.sample_ready = 1'b0;
    send_byte(8'hAA);
    repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
    send_byte(8'h11);
    send_byte(8'h22);
`ifdef SAMPLE_TIMEOUT_EN
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL t5_count: got %0d want 1", fifo_count); end
    vectors++; if (fir.sample_out !== 16'h2211) begin miscompares++; $display("FAIL t5_out: got %h want 2211", fir.sample_out); end
    $display("timeout resync checked");
`else
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL t5_count: got %0d want 1", fifo_count); end
    vectors++; if (fir.sample_out !== 16'h11AA) begin miscompares++; $display("FAIL t5_out: got %h want 11aa", fir.sample_out); end
    send_byte(8'h33);
    vectors++; if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL t5_pending: got %0d want 2", fifo_count); end
    fir.sample_ready = 1'b1;
    @(negedge clk);
    vectors++; if (fir.sample_out !== 16'h3322) begin miscompares++; $display("FAIL t5_second: got %h want 3322", fir.sample_out); end
    $display("long gap without timeout checked");
`endif
    fir.sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL t5_drain: got %0d want 0", fifo_count); end
    fir.sample_ready = 1'b0;
  endtask

  initial begin
    fir.sample_ready = 1'b0;
    test_reset();
    test_single_sample();
    test_overflow();
    test_full_push_pop();
    test_signed_and_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
